serial_sub16: RTL and testbench
===============================

SERIAL_SUB16 -- requirements
Module: serial_sub16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand set presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port x  input  WIDTH  minuend.
REQ-007 SHALL have port y  input  WIDTH  subtrahend.
REQ-008 SHALL have port bin  input  1  borrow-in into bit 0.
REQ-009 SHALL have port d  output  WIDTH  difference x - y - bin, mod 2^WIDTH.
REQ-010 SHALL have port bout  output  1  borrow out of the MSB: 1 when x < y + bin, unsigned.
REQ-011 SHALL have port ovf  output  1  two's-complement signed overflow of the subtraction.
REQ-012 SHALL have port out_valid  output  1  d/bout/ovf hold a completed result.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-015 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-016 SHALL, in IDLE with in_valid=1, capture x, y and bin into internal registers, clear the bit counter to 0, and enter BUSY on that edge.
REQ-017 SHALL, in BUSY, process exactly one bit per clock, LSB first.
  - diff bit = a ^ b ^ br.
  - next br = (~a & b) | (~(a ^ b) & br).
  - br is initialised from bin.
REQ-018 SHALL shift each diff bit into the result register from the MSB end, so that after WIDTH bits d[i] corresponds to bit i.
REQ-019 SHALL, on the edge that processes bit WIDTH-1:
  - latch bout from the final br;
  - latch ovf = (x[MSB] != y[MSB]) && (d[MSB] != x[MSB]);
  - enter DONE.
REQ-020 SHALL assert out_valid exactly WIDTH rising edges after the accepting edge (16 for the default).
REQ-021 SHALL hold d, bout, ovf and out_valid stable in DONE until out_ready=1 is sampled; on that edge it returns to IDLE.
REQ-022 SHALL ignore in_valid, x, y and bin while in BUSY or DONE; there is no overlap of operations.
REQ-023 SHALL allow back-to-back operations: after the out handshake edge, in_ready=1 in the next cycle and a new operand set is accepted on the following edge.
REQ-024 SHALL keep d, bout and ovf at their last values while in IDLE; only the result of a completed operation is ever flagged valid.
REQ-025 SHALL use a bit counter of width clog2(WIDTH), and the counter shall not wrap within an operation.

Reset
REQ-026 SHALL, on rst_n=0 and independent of clk, force:
  - state IDLE, counter 0, borrow register 0;
  - d=0, bout=0, ovf=0, out_valid=0, in_ready=1.
REQ-027 SHALL, on reset asserted mid-BUSY or in DONE, discard the operation and produce no out_valid afterwards.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Structure
REQ-029 SHALL place the FSM state typedef (IDLE/BUSY/DONE) and the default WIDTH constant in a shared package, sub_pkg.
REQ-030 SHALL instantiate one sub-module, full_sub: a 1-bit full subtractor with outputs diff and borrow and inputs a, b, bin; it is used for the per-bit datapath.

Verification
REQ-031 SHALL cover: x=0x0005, y=0x0003, bin=0 -> d=0x0002, bout=0, ovf=0, out_valid exactly 16 edges after accept.
REQ-032 SHALL cover: x=0x0000, y=0x0001, bin=0 -> d=0xFFFF, bout=1, ovf=0.
REQ-033 SHALL cover: x=0x8000, y=0x0001, bin=0 -> d=0x7FFF, bout=0, ovf=1; and x=0x7FFF, y=0xFFFF -> d=0x8000, bout=1, ovf=1.
REQ-034 SHALL cover: x=0x1234, y=0x1234, bin=1 -> d=0xFFFF, bout=1, ovf=0.
REQ-035 SHALL cover backpressure: out_ready held 0 for 5 cycles in DONE -> outputs stable throughout, in_ready=0; also in_valid toggled during BUSY -> ignored.
REQ-036 SHALL cover reset: rst_n pulsed low at BUSY bit 7 -> all outputs at reset values immediately, no out_valid afterwards, next operation correct.

Source files
------------

// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_pkg
// Description : Shared types, constants and helpers for the bit-serial
//               subtractor (serial_sub16) and its per-bit full subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    // Default operand / result width in bits.
    localparam int DEFAULT_WIDTH = 16;

    // Operation sequencing: wait for operands, shift bits, present result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width; never narrower than one bit so a degenerate
    // WIDTH still yields a legal vector.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Signed overflow of x - y: operands of opposite sign and the result's
    // sign differs from the minuend's.
    function automatic logic sub_ovf(input logic x_msb,
                                     input logic y_msb,
                                     input logic d_msb);
        return (x_msb != y_msb) && (d_msb != x_msb);
    endfunction

endpackage : sub_pkg
`default_nettype wire

// File: rtl/full_sub.sv
`default_nettype none
// ============================================================================
// Module      : full_sub
// Description : One-bit full subtractor, diff = a - b - bin with borrow out.
// Revision    : 1.0 - initial release
// ============================================================================
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic borrow
);

    // Borrow is generated when a=0,b=1, or propagated when a==b.
    always_comb begin
        diff   = a ^ b ^ bin;
        borrow = (~a & b) | (~(a ^ b) & bin);
    end

endmodule : full_sub
`default_nettype wire

// File: rtl/serial_sub16.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub16
// Description : Bit-serial subtractor. Accepts x, y, bin with a valid/ready
//               handshake, computes x - y - bin one bit per clock LSB first,
//               and presents d / bout / ovf until the consumer takes them.
//               WIDTH must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub16
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
    localparam int             MSB      = WIDTH - 1;

    state_t           state;
    state_t           state_nxt;

    // Captured operands; held for the whole operation so the inputs are
    // free to change once the operand set has been accepted.
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    // Partial difference, filled from the MSB end as bits are produced.
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             br;

    logic             bit_a;
    logic             bit_b;
    logic             bit_d;
    logic             bit_br;
    logic             last_bit;
    logic             accept;
    logic             step;
    logic             finish;

    assign bit_a    = x_reg[cnt];
    assign bit_b    = y_reg[cnt];
    assign last_bit = (cnt == LAST_BIT);
    assign accept   = (state == IDLE) && in_valid;
    assign step     = (state == BUSY);
    assign finish   = step && last_bit;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    full_sub u_full_sub (
        .a      (bit_a),
        .b      (bit_b),
        .bin    (br),
        .diff   (bit_d),
        .borrow (bit_br)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, run WIDTH bit steps, wait for the consumer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture and per-bit datapath (borrow chain, shift, counter).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= '0;
            y_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
        end else if (accept) begin
            x_reg <= x;
            y_reg <= y;
            br    <= bin;
            cnt   <= '0;
        end else if (step) begin
            acc <= {bit_d, acc[WIDTH-1:1]};
            br  <= bit_br;
            // Counter parks on the last bit rather than wrapping.
            if (!last_bit) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Result registers: only updated by the final bit step, so they keep
    // the previous result through IDLE and BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d    <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (finish) begin
            d    <= {bit_d, acc[WIDTH-1:1]};
            bout <= bit_br;
            ovf  <= sub_ovf(x_reg[MSB], y_reg[MSB], bit_d);
        end
    end

endmodule : serial_sub16
`default_nettype wire

// File: tb/tb_serial_sub16.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub16
// Description : Self-checking bench for serial_sub16: table of directed
//               vectors plus backpressure, input-noise and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;

    int tests;
    int fails;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        bin;
        logic [15:0] d;
        logic        bout;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    serial_sub16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .bin       (bin),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if something hangs beyond every bounded wait.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Runs one operation starting at a negedge; ends at the negedge after the
    // output handshake, so consecutive calls are back-to-back.
    task automatic run_op(input logic [15:0] xv, input logic [15:0] yv, input logic bv,
                          input logic [15:0] ed, input logic eb, input logic eo,
                          input int hold, input bit noisy, input string tag);
        int n;
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        x        = xv;
        y        = yv;
        bin      = bv;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (noisy) begin
                in_valid = ~in_valid;
                x        = x ^ 16'hA5A5;
                y        = ~y;
                bin      = ~bin;
            end
        end
        in_valid = 1'b0;
        check({tag, " latency"}, n, 32'd16);
        check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, " d"}, {16'd0, d}, {16'd0, ed});
        check({tag, " bout"}, {31'd0, bout}, {31'd0, eb});
        check({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold out_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
            check({tag, " hold result"}, {14'd0, d, bout, ovf}, {14'd0, ed, eb, eo});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " post out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, " post in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, " post result kept"}, {14'd0, d, bout, ovf}, {14'd0, ed, eb, eo});
    endtask

    initial begin
        bit seen;
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = 16'h0;
        y         = 16'h0;
        bin       = 1'b0;

        //          x         y         bin   d         bout  ovf
        vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
        vecs[6] = '{16'h1234, 16'hABCD, 1'b0, 16'h6667, 1'b1, 1'b0};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[9] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1};

        // Reset values before any clock edge.
        #3;
        check("reset d", {16'd0, d}, 32'd0);
        check("reset bout", {31'd0, bout}, 32'd0);
        check("reset ovf", {31'd0, ovf}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table; vector 5 also has inputs churning during BUSY.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].bin, vecs[i].d, vecs[i].bout,
                   vecs[i].ovf, 0, (i == 5), $sformatf("vec%0d", i));
        end

        // Backpressure: five cycles stalled in DONE, with noisy inputs in BUSY.
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 5, 1'b1, "bp");

        // Reset asserted while bit 7 is being processed.
        in_valid = 1'b1;
        x        = 16'h5555;
        y        = 16'h1111;
        bin      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst d", {16'd0, d}, 32'd0);
        check("midrst bout", {31'd0, bout}, 32'd0);
        check("midrst ovf", {31'd0, ovf}, 32'd0);
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst no out_valid", {31'd0, seen}, 32'd0);
        run_op(16'h5555, 16'h1111, 1'b0, 16'h4444, 1'b0, 1'b0, 0, 1'b0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_sub16
`default_nettype wire
